// File: rtl/stopwatch_bcd_counter_if.sv
// Stopwatch bundle: slow tick and control pulses in, BCD digits and status out.
// The lap/lap_active pair exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_bcd_counter_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;
`ifdef STOPWATCH_LAP_EN
    logic       lap;
    logic       lap_active;

    modport master (
        output tick_in, start_stop, clear, lap,
        input  sec_ones, sec_tens, min_ones, min_tens, running, rollover, lap_active
    );
    modport slave (
        input  tick_in, start_stop, clear, lap,
        output sec_ones, sec_tens, min_ones, min_tens, running, rollover, lap_active
    );
`else
    modport master (
        output tick_in, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );
    modport slave (
        input  tick_in, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );
`endif
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch counting both edges of the divider toggle; digits step SYNC_STAGES+1 clk after a tick edge.
// STOPWATCH_LAP_EN adds a lap snapshot shown on the digit outputs while lap_active is set.
module stopwatch_bcd_counter #(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    stopwatch_bcd_counter_if.slave bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            running;
    logic [SYNC_STAGES:0] sync;
    logic            tick_ev;
    logic [PW-1:0]   presc;
    logic [3:0]      s1;
    logic [3:0]      s10;
    logic [3:0]      m1;
    logic [3:0]      m10;
    logic            roll;
    logic            count_en;
    logic            sec_step;
    logic            at_max;
    logic [15:0]     live;
    logic [15:0]     shown;

    // Top bit is a history flop behind the synchroniser so either edge yields one tick_ev.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-1:0], bus.tick_in};
    end

    assign tick_ev = sync[SYNC_STAGES] ^ sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else if (bus.start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    assign count_en = tick_ev && (state == RUN) && !bus.clear;
    assign sec_step = count_en && (presc == PRESC_LAST);
    assign at_max   = (m10 == 4'd9) && (m1 == 4'd9) && (s10 == 4'd5) && (s1 == 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           presc <= '0;
        else if (bus.clear) presc <= '0;
        else if (count_en)  presc <= sec_step ? '0 : presc + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= '0;
            s10 <= '0;
            m1  <= '0;
            m10 <= '0;
        end else if (bus.clear) begin
            s1  <= '0;
            s10 <= '0;
            m1  <= '0;
            m10 <= '0;
        end else if (sec_step) begin
            if (s1 != 4'd9) begin
                s1 <= s1 + 4'd1;
            end else begin
                s1 <= '0;
                if (s10 != 4'd5) begin
                    s10 <= s10 + 4'd1;
                end else begin
                    s10 <= '0;
                    if (m1 != 4'd9) begin
                        m1 <= m1 + 4'd1;
                    end else begin
                        m1  <= '0;
                        m10 <= (m10 == 4'd9) ? 4'd0 : m10 + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) roll <= 1'b0;
        else      roll <= sec_step && at_max;
    end

    assign live = {m10, m1, s10, s1};

`ifdef STOPWATCH_LAP_EN
    logic        lap_act;
    logic [15:0] snap;

    // A lap pulse toggles the snapshot only while running; clear always drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_act <= 1'b0;
            snap    <= '0;
        end else if (bus.clear) begin
            lap_act <= 1'b0;
        end else if (bus.lap && (state == RUN)) begin
            if (!lap_act) begin
                lap_act <= 1'b1;
                snap    <= live;
            end else begin
                lap_act <= 1'b0;
            end
        end
    end

    assign shown          = lap_act ? snap : live;
    assign bus.lap_active = lap_act;
`else
    assign shown = live;
`endif

    assign bus.min_tens = shown[15:12];
    assign bus.min_ones = shown[11:8];
    assign bus.sec_tens = shown[7:4];
    assign bus.sec_ones = shown[3:0];
    assign bus.running  = running;
    assign bus.rollover = roll;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed plus randomized bench for stopwatch_bcd_counter against an elapsed-seconds reference model.
module tb_stopwatch_bcd_counter;
    localparam int S   = 2;
    localparam int TPS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_bcd_counter_if sw_if ();

    stopwatch_bcd_counter #(
        .SYNC_STAGES  (S),
        .TICKS_PER_SEC(TPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sw_if.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed seconds, ticks into the current second, run state.
    int m_secs  = 0;
    int m_ticks = 0;
    int m_state = 0;   // 0 idle, 1 run, 2 pause
    bit m_roll  = 0;

    function automatic logic [15:0] exp_dig(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_dig();
        return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"}, 32'(dut_dig()), 32'(exp_dig(m_secs)));
        check({tag, ".running"}, 32'(sw_if.running), 32'(m_state == 1));
    endtask

    task automatic model_tick();
        if (m_state == 1) begin
            m_ticks++;
            if (m_ticks == TPS) begin
                m_ticks = 0;
                if (m_secs == 5999) m_roll = 1;
                m_secs = (m_secs + 1) % 6000;
            end
        end
    endtask

    task automatic model_ss();
        m_state = (m_state == 1) ? 2 : 1;
    endtask

    task automatic model_clear();
        m_state = 0;
        m_secs  = 0;
        m_ticks = 0;
        m_roll  = 0;
    endtask

    task automatic flush();
        repeat (S + 1) @(negedge clk);
        m_roll = 0;
    endtask

    task automatic fast_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sw_if.tick_in = ~sw_if.tick_in;
            model_tick();
        end
        flush();
    endtask

    // One tick edge, checking the digits hold for S cycles and change on the next.
    task automatic tick_timed(input string tag);
        logic [15:0] old;
        old = exp_dig(m_secs);
        @(negedge clk) sw_if.tick_in = ~sw_if.tick_in;
        model_tick();
        repeat (S) @(negedge clk);
        check({tag, ".hold"}, 32'(dut_dig()), 32'(old));
        @(negedge clk);
        check({tag, ".step"}, 32'(dut_dig()), 32'(exp_dig(m_secs)));
        check({tag, ".roll"}, 32'(sw_if.rollover), 32'(m_roll));
        m_roll = 0;
    endtask

    task automatic pulse_ss();
        @(negedge clk) sw_if.start_stop = 1'b1;
        @(negedge clk) sw_if.start_stop = 1'b0;
        model_ss();
    endtask

    task automatic pulse_clear();
        @(negedge clk) sw_if.clear = 1'b1;
        @(negedge clk) sw_if.clear = 1'b0;
        model_clear();
    endtask

    // Tick edge whose tick_ev lands in the same cycle as the control pulses.
    task automatic tick_with(input bit do_ss, input bit do_clr);
        @(negedge clk) sw_if.tick_in = ~sw_if.tick_in;
        repeat (S) @(negedge clk);
        sw_if.start_stop = do_ss;
        sw_if.clear      = do_clr;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        if (do_clr) begin
            model_clear();
        end else begin
            model_tick();
            if (do_ss) model_ss();
        end
    endtask

    initial begin
        int r;
        sw_if.tick_in    = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.lap        = 1'b0;
`endif
        rst = 1'b0;

        // Reset held while the tick toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) sw_if.tick_in = ~sw_if.tick_in;
        end
        @(negedge clk) sw_if.tick_in = 1'b1;
        check_all("reset");
        check("reset.roll", 32'(sw_if.rollover), 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (6) @(negedge clk);
        check_all("release");

        // Start and count 6 edges to 00:03.
        pulse_ss();
        check("start.running", 32'(sw_if.running), 32'd1);
        for (int i = 0; i < 6; i++) tick_timed("count");
        check("count.0003", 32'(dut_dig()), 32'h0003);

        // Preload to 01:59, carry into minutes, then run to the 99:59 rollover.
        pulse_clear();
        pulse_ss();
        fast_edges(238);
        check("pre.0159", 32'(dut_dig()), 32'h0159);
        tick_timed("min_carry_a");
        tick_timed("min_carry_b");
        check("pre.0200", 32'(dut_dig()), 32'h0200);
        fast_edges((5999 - 120) * TPS);
        check("pre.9959", 32'(dut_dig()), 32'h9959);
        tick_timed("wrap_a");
        tick_timed("wrap_b");
        check("wrap.0000", 32'(dut_dig()), 32'h0000);
        @(negedge clk);
        check("wrap.roll_drop", 32'(sw_if.rollover), 32'd0);
        check_all("wrap.after");

        // Pause at 00:05 with an odd prescaler phase, then resume.
        pulse_clear();
        pulse_ss();
        fast_edges(11);
        check_all("pause.0005");
        pulse_ss();
        check("pause.running", 32'(sw_if.running), 32'd0);
        fast_edges(10);
        check_all("pause.held");
        pulse_ss();
        tick_timed("resume_a");
        tick_timed("resume_b");
        check("resume.0006", 32'(dut_dig()), 32'h0006);

        // Clear + start_stop + tick_ev together at 00:42 with a pending step.
        pulse_clear();
        pulse_ss();
        fast_edges(85);
        check_all("co.0042");
        tick_with(1'b1, 1'b1);
        check_all("co.clear");
        pulse_ss();
        tick_timed("co.presc0");
        tick_timed("co.presc1");
        check("co.0001", 32'(dut_dig()), 32'h0001);

        // tick_ev with start_stop in RUN is counted; in PAUSE it is not.
        tick_timed("co.odd");
        tick_with(1'b1, 1'b0);
        check_all("co.run_ss");
        tick_with(1'b1, 1'b0);
        check_all("co.pause_ss");
        tick_timed("co.after_a");
        tick_timed("co.after_b");
        check_all("co.after");

        // Randomized mix of ticks and control pulses.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                flush();
                pulse_clear();
                check_all("rnd.clear");
            end else if (r <= 2) begin
                flush();
                pulse_ss();
                check_all("rnd.ss");
            end else begin
                @(negedge clk) sw_if.tick_in = ~sw_if.tick_in;
                model_tick();
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
            end
        end
        flush();
        check_all("rnd.end");

        // Asynchronous reset mid-count.
        pulse_clear();
        pulse_ss();
        fast_edges(7);
        check_all("mid.0003");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all("mid.async");
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        check_all("mid.release");

`ifdef STOPWATCH_LAP_EN
        pulse_ss();
        fast_edges(20);
        @(negedge clk) sw_if.lap = 1'b1;
        @(negedge clk) sw_if.lap = 1'b0;
        check("lap.active", 32'(sw_if.lap_active), 32'd1);
        check("lap.snap", 32'(dut_dig()), 32'h0010);
        fast_edges(4);
        check("lap.held", 32'(dut_dig()), 32'h0010);
        @(negedge clk) sw_if.lap = 1'b1;
        @(negedge clk) sw_if.lap = 1'b0;
        check("lap.drop", 32'(sw_if.lap_active), 32'd0);
        check_all("lap.live");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
